// File: rtl/pipeline_pkg.sv
// Shared types for the decode-stage hazard controller: FSM states, control
// bundle driven to the pipeline registers, and register-number constants.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FROZEN = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef struct packed {
    logic pcWrite;
    logic ifidWrite;
    logic ifidFlush;
    logic idexBubble;
  } hazard_ctrl_t;

  localparam hazard_ctrl_t CTRL_RUN    = 4'b1100;
  localparam hazard_ctrl_t CTRL_STALL  = 4'b0001;
  localparam hazard_ctrl_t CTRL_FLUSH  = 4'b1111;
  localparam hazard_ctrl_t CTRL_FROZEN = 4'b0001;
  localparam hazard_ctrl_t CTRL_RESET  = 4'b0011;

  function automatic logic srcMatch(input logic uses, input logic [4:0] src,
                                    input logic [4:0] dst);
    return uses && (src == dst);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clr)
      count <= '0;
    else if (inc && (count != {W{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Decode-side pipeline sequencer: load-use stalls, redirect flushes and the
// debug freeze/drain handshake, plus saturating stall/flush event counters.
module pipeline_hazard_controller
  import pipeline_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int DRAIN_CYCLES      = 3,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_write_reg,
  input  logic             ex_redirect,
  input  logic             freeze_req,
  input  logic             clr_counters,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             freeze_ack,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int DW = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES);
  localparam logic [1:0]    STALL_INIT = 2'(LOAD_STALL_CYCLES - 1);

  state_e       state;
  logic [1:0]   stallCnt;
  logic [DW-1:0] drainCnt;
  logic         hz;
  logic         stallCycle;
  hazard_ctrl_t ctrl;

  assign hz = id_valid && ex_mem_read && (ex_write_reg != REG_ZERO) &&
              (srcMatch(id_uses_rs, id_rs, ex_write_reg) ||
               srcMatch(id_uses_rt, id_rt, ex_write_reg));

  // Hazard is only honoured from RUN; a frozen pipe has nothing to stall.
  assign stallCycle = !ex_redirect && ((state == STALL) || ((state == RUN) && hz));

  always_comb begin
    ctrl = CTRL_RUN;
    if (reset)                 ctrl = CTRL_RESET;
    else if (ex_redirect)      ctrl = CTRL_FLUSH;
    else if (stallCycle)       ctrl = CTRL_STALL;
    else if (state == FROZEN)  ctrl = CTRL_FROZEN;
  end

  assign pc_write    = ctrl.pcWrite;
  assign ifid_write  = ctrl.ifidWrite;
  assign ifid_flush  = ctrl.ifidFlush;
  assign idex_bubble = ctrl.idexBubble;
  assign freeze_ack  = !reset && (state == FROZEN) && (drainCnt == DRAIN_LAST);

  always_ff @(posedge clk) begin
    if (reset || ex_redirect) begin
      state    <= RUN;
      stallCnt <= 2'd0;
      drainCnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (hz) begin
            if (LOAD_STALL_CYCLES > 1) begin
              state    <= STALL;
              stallCnt <= STALL_INIT;
            end
          end else if (freeze_req) begin
            state    <= FROZEN;
            drainCnt <= '0;
          end
        end
        STALL: begin
          stallCnt <= stallCnt - 2'd1;
          if (stallCnt <= 2'd1) state <= RUN;
        end
        FROZEN: begin
          if (!freeze_req) begin
            state    <= RUN;
            drainCnt <= '0;
          end else if (drainCnt != DRAIN_LAST) begin
            drainCnt <= drainCnt + 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) uStallCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stallCycle),
    .clr   (clr_counters),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) uFlushCnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ex_redirect),
    .clr   (clr_counters),
    .count (flush_count)
  );

endmodule
